fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Front end of the single-issue MIPS core. It owns the PC, fetches instruction words from instruction memory over a request/ready handshake, and presents the opcode and fields to the main control decoder. It then takes back the decoder's PC operation plus the ALU zero flag and jr detect, and computes the next PC. Branch, jump, jal-link and jr redirection are resolved here.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC and instruction-memory address width; fixed at 32 for this core

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, address valid
imem_addr  out  32  fetch address (current PC)
imem_ready  in  1  instruction memory has imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instruction register valid; decoder outputs are meaningful
instr  out  32  latched instruction word
opcode  out  6  instr[31:26], to control decoder
funct  out  6  instr[5:0], to ALU/jr control
pc  out  32  PC of the instruction in instr
link_addr  out  32  pc+4, write-back value for jal
pc_op  in  2  decoder PC operation: 00 seq, 01 beq, 10 jump, 11 bne
is_jr  in  1  jr detected; overrides pc_op
jr_target  in  32  rs register value for jr
alu_zero  in  1  ALU zero flag for the current instruction
ex_stall  in  1  hold current instruction (back end busy)
fault  out  1  sticky misaligned-target fault

Behaviour:
- Reset (sync, high) values: state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0.
- Reset asserted in any state abandons any outstanding fetch. imem_req is 0 in the cycle after reset is sampled.
- States: FETCH, EXEC, HALT. State is registered; outputs are decoded from the registers.
- FETCH:
  - imem_req=1 and imem_addr=pc every cycle until imem_ready=1 is sampled.
  - On imem_ready: instr<=imem_rdata and state<=EXEC.
  - imem_ready while imem_req=0 is ignored.
  - Minimum fetch latency is 1 cycle: instr_valid rises the cycle after ready.
- EXEC:
  - instr_valid=1 and imem_req=0.
  - opcode, funct, link_addr and pc are stable for the whole state.
  - If ex_stall=1: remain in EXEC with pc and instr unchanged.
  - Otherwise: pc<=next_pc and state<=FETCH, so instr_valid drops the next cycle.
- next_pc, all arithmetic modulo 2^32, wrap silently:
  - pc4 = pc+4.
  - bt = pc4 + (sign_extend(instr[15:0]) << 2).
  - is_jr=1 -> jr_target. is_jr has priority over pc_op.
  - pc_op 00 -> pc4.
  - pc_op 01 -> alu_zero ? bt : pc4.
  - pc_op 10 -> {pc4[31:28], instr[25:0], 2'b00}.
  - pc_op 11 -> alu_zero ? pc4 : bt.
- link_addr = pc+4, combinational from the pc register; valid in EXEC.
- Misalignment:
  - If next_pc[1:0] != 0 when leaving EXEC (only reachable via jr): pc is not updated, state<=HALT, fault<=1.
  - HALT: imem_req=0, instr_valid=0, fault=1. HALT is left only by reset.
- No instruction word is ever presented twice: one EXEC visit per successful fetch.
- One instruction in flight. No prefetch, no branch delay slot.

Test Plan:
1. Reset with RESET_PC=0; imem_ready asserted 2 cycles after imem_req; rdata=32'h2008_0005 -> imem_addr=0, opcode=6'h08, instr_valid high 1 cycle after ready; with pc_op=00 next fetch address=0x4.
2. pc=0x10, instr=32'h1000_FFFC (beq, imm=-4), pc_op=01 -> alu_zero=1 gives next imem_addr=0x04; repeated with alu_zero=0 gives 0x14.
3. pc=0x1000_0000, instr=32'h0800_0040, pc_op=10 -> next imem_addr=0x1000_0100. With the jal word 32'h0C00_0040 -> link_addr=0x1000_0004 during EXEC.
4. pc=0x20, instr bne with imm=2, pc_op=11, alu_zero=0 -> next 0x2C. Wrap case: pc=32'hFFFF_FFFC, pc_op=00 -> next 0x0.
5. ex_stall held 3 cycles in EXEC -> instr_valid stays 1, pc and instr unchanged, imem_req=0. Release -> FETCH next cycle. Reset raised mid-FETCH -> imem_req=0 next cycle, pc=RESET_PC.
6. is_jr=1, jr_target=0x0000_0402 -> fault=1, state HALT, imem_req stays 0 for 10+ cycles, pc unchanged. Reset clears fault and fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Front end of the single-issue MIPS core: owns the PC, fetches over a req/ready
// handshake, holds the instruction for the decoder and resolves the next PC.
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    input  logic [1:0]        pc_op,
    input  logic              is_jr,
    input  logic [31:0]       jr_target,
    input  logic              alu_zero,
    input  logic              ex_stall,
    output logic              fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_r, pc_nx;
    logic [31:0]       instr_r, instr_nx;
    logic              req_r, req_nx;
    logic              fault_r, fault_nx;

    logic [ADDR_W-1:0] pc4, branch_target, jump_target, next_pc;

    always_comb begin
        pc4           = pc_r + 32'd4;
        branch_target = pc4 + {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
        jump_target   = {pc4[31:28], instr_r[25:0], 2'b00};
        next_pc       = pc4;
        if (is_jr) begin
            next_pc = jr_target;
        end else begin
            case (pc_op)
                2'b01:   next_pc = alu_zero ? branch_target : pc4;
                2'b10:   next_pc = jump_target;
                2'b11:   next_pc = alu_zero ? pc4 : branch_target;
                default: next_pc = pc4;
            endcase
        end
    end

    // The request is registered so the cycle after reset never carries a stale request
    // and a ready seen while no request is outstanding cannot be taken as a fetch.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_r;
        instr_nx = instr_r;
        req_nx   = 1'b0;
        fault_nx = fault_r;
        case (state)
            FETCH: begin
                req_nx = 1'b1;
                if (req_r && imem_ready) begin
                    instr_nx = imem_rdata;
                    state_nx = EXEC;
                    req_nx   = 1'b0;
                end
            end
            EXEC: begin
                if (!ex_stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_nx = HALT;
                        fault_nx = 1'b1;
                    end else begin
                        pc_nx    = next_pc;
                        state_nx = FETCH;
                        req_nx   = 1'b1;
                    end
                end
            end
            HALT: begin
                fault_nx = 1'b1;
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'd0;
            req_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state   <= state_nx;
            pc_r    <= pc_nx;
            instr_r <= instr_nx;
            req_r   <= req_nx;
            fault_r <= fault_nx;
        end
    end

    assign imem_req    = req_r && (state == FETCH);
    assign imem_addr   = pc_r;
    assign instr_valid = (state == EXEC);
    assign instr       = instr_r;
    assign opcode      = instr_r[31:26];
    assign funct       = instr_r[5:0];
    assign pc          = pc_r;
    assign link_addr   = pc4;
    assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer, checked against a PC-level
// reference model of the instruction-flow rules.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [1:0]  pc_op = 2'b00;
    logic        is_jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        alu_zero = 1'b0;
    logic        ex_stall = 1'b0;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mPc;
    logic [31:0] mInstr;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .opcode     (opcode),
        .funct      (funct),
        .pc         (pc),
        .link_addr  (link_addr),
        .pc_op      (pc_op),
        .is_jr      (is_jr),
        .jr_target  (jr_target),
        .alu_zero   (alu_zero),
        .ex_stall   (ex_stall),
        .fault      (fault)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference next-PC, written from the instruction-flow rules with plain arithmetic.
    function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] w,
                                              input logic [1:0] op, input logic jr,
                                              input logic [31:0] tgt, input logic z);
        logic [31:0] p4;
        logic [31:0] bt;
        shortint     simm;
        int          off;
        p4   = curPc + 32'd4;
        simm = w[15:0];
        off  = int'(simm) * 4;
        bt   = p4 + 32'(off);
        if (jr) return tgt;
        case (op)
            2'd1:    return z ? bt : p4;
            2'd2:    return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
            2'd3:    return z ? p4 : bt;
            default: return p4;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        reset      = 1'b1;
        imem_ready = 1'b0;
        ex_stall   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mPc   = RESET_PC;
        checkOutput("rst_req",   32'(imem_req),    32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_pc",    pc,               RESET_PC);
        checkOutput("rst_instr", instr,            32'd0);
        checkOutput("rst_fault", 32'(fault),       32'd0);
    endtask

    // Acts as instruction memory: waits for a request, stalls lat cycles, then returns word.
    task automatic applyStimulus(input logic [31:0] word, input int lat);
        int waitCnt;
        waitCnt = 0;
        while (imem_req !== 1'b1 && waitCnt < 20) begin
            @(negedge clock);
            waitCnt++;
        end
        checkOutput("req_seen",   32'(imem_req), 32'd1);
        checkOutput("fetch_addr", imem_addr,     mPc);
        for (int i = 0; i < lat; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clock);
            checkOutput("req_hold",  32'(imem_req),    32'd1);
            checkOutput("addr_hold", imem_addr,        mPc);
            checkOutput("valid_low", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        mInstr     = word;
        checkOutput("valid_hi",  32'(instr_valid), 32'd1);
        checkOutput("instr",     instr,            word);
        checkOutput("opcode",    32'(opcode),      word >> 26);
        checkOutput("funct",     32'(funct),       word & 32'h3F);
        checkOutput("exec_pc",   pc,               mPc);
        checkOutput("link_addr", link_addr,        mPc + 32'd4);
        checkOutput("exec_req",  32'(imem_req),    32'd0);
    endtask

    task automatic execInstr(input logic [1:0] op, input logic jr, input logic [31:0] tgt,
                             input logic z, input int stall);
        logic [31:0] nxt;
        for (int i = 0; i < stall; i++) begin
            ex_stall  = 1'b1;
            pc_op     = 2'($urandom);
            is_jr     = 1'($urandom);
            jr_target = $urandom;
            alu_zero  = 1'($urandom);
            @(negedge clock);
            checkOutput("stall_valid", 32'(instr_valid), 32'd1);
            checkOutput("stall_pc",    pc,               mPc);
            checkOutput("stall_instr", instr,            mInstr);
            checkOutput("stall_req",   32'(imem_req),    32'd0);
        end
        ex_stall  = 1'b0;
        pc_op     = op;
        is_jr     = jr;
        jr_target = tgt;
        alu_zero  = z;
        @(negedge clock);
        nxt = refNextPc(mPc, mInstr, op, jr, tgt, z);
        if (nxt[1:0] != 2'b00) begin
            checkOutput("halt_fault", 32'(fault),       32'd1);
            checkOutput("halt_valid", 32'(instr_valid), 32'd0);
            checkOutput("halt_req",   32'(imem_req),    32'd0);
            checkOutput("halt_pc",    pc,               mPc);
        end else begin
            mPc = nxt;
            checkOutput("next_valid", 32'(instr_valid), 32'd0);
            checkOutput("next_req",   32'(imem_req),    32'd1);
            checkOutput("next_addr",  imem_addr,        mPc);
            checkOutput("next_fault", 32'(fault),       32'd0);
        end
        pc_op     = 2'($urandom);
        is_jr     = 1'($urandom);
        jr_target = $urandom;
        alu_zero  = 1'($urandom);
    endtask

    // Steers the PC anywhere aligned with a jr instruction.
    task automatic setPc(input logic [31:0] target);
        applyStimulus(32'h03E0_0008, $urandom_range(0, 1));
        execInstr(2'b00, 1'b1, target, 1'b0, 0);
    endtask

    initial begin
        @(negedge clock);
        applyReset();

        $display("[TB] sequential fetch after reset");
        applyStimulus(32'h2008_0005, 2);
        checkOutput("t1_opcode", 32'(opcode), 32'h08);
        execInstr(2'b00, 1'b0, 32'd0, 1'b0, 0);
        checkOutput("t1_next", imem_addr, 32'h0000_0004);

        $display("[TB] beq taken / not taken");
        setPc(32'h10);
        applyStimulus(32'h1000_FFFC, 1);
        execInstr(2'b01, 1'b0, 32'd0, 1'b1, 0);
        checkOutput("t2_taken", imem_addr, 32'h0000_0004);
        setPc(32'h10);
        applyStimulus(32'h1000_FFFC, 0);
        execInstr(2'b01, 1'b0, 32'd0, 1'b0, 0);
        checkOutput("t2_fall", imem_addr, 32'h0000_0014);

        $display("[TB] jump and jal link");
        setPc(32'h1000_0000);
        applyStimulus(32'h0800_0040, 0);
        execInstr(2'b10, 1'b0, 32'd0, 1'b0, 0);
        checkOutput("t3_jump", imem_addr, 32'h1000_0100);
        setPc(32'h1000_0000);
        applyStimulus(32'h0C00_0040, 1);
        checkOutput("t3_link", link_addr, 32'h1000_0004);
        execInstr(2'b10, 1'b0, 32'd0, 1'b0, 0);

        $display("[TB] bne and PC wrap");
        setPc(32'h20);
        applyStimulus(32'h1400_0002, 0);
        execInstr(2'b11, 1'b0, 32'd0, 1'b0, 0);
        checkOutput("t4_bne", imem_addr, 32'h0000_002C);
        setPc(32'hFFFF_FFFC);
        applyStimulus(32'h0000_0020, 0);
        checkOutput("t4_link_wrap", link_addr, 32'h0000_0000);
        execInstr(2'b00, 1'b0, 32'd0, 1'b0, 0);
        checkOutput("t4_wrap", imem_addr, 32'h0000_0000);

        $display("[TB] execute stall and reset mid-fetch");
        applyStimulus(32'h0123_4567, 1);
        execInstr(2'b00, 1'b0, 32'd0, 1'b0, 3);
        checkOutput("t5_release", imem_addr, 32'h0000_0004);
        applyReset();
        checkOutput("t5_rst_pc", pc, RESET_PC);

        $display("[TB] misaligned jr halts");
        applyStimulus(32'h03E0_0008, 1);
        execInstr(2'b00, 1'b1, 32'h0000_0402, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clock);
            checkOutput("halt_req_hold",   32'(imem_req),    32'd0);
            checkOutput("halt_valid_hold", 32'(instr_valid), 32'd0);
            checkOutput("halt_fault_hold", 32'(fault),       32'd1);
            checkOutput("halt_pc_hold",    pc,               mPc);
        end
        applyReset();
        applyStimulus(32'h2008_0005, 0);
        checkOutput("t6_resume_pc", pc, RESET_PC);
        execInstr(2'b00, 1'b0, 32'd0, 1'b0, 0);

        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  op;
            logic        z;
            int          stall;
            op    = 2'($urandom);
            z     = 1'($urandom);
            stall = $urandom_range(0, 2);
            applyStimulus($urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)
                execInstr(op, 1'b1, $urandom & 32'hFFFF_FFFC, z, stall);
            else
                execInstr(op, 1'b0, $urandom, z, stall);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
